// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and flag bit indices for the sequential ALU.
// ALU_SEQ_MUL_EN makes op 12 a multi-cycle unsigned multiply; otherwise it is illegal.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_INC = 4'd2;
   localparam logic [3:0] OP_DEC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_SAR = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   localparam int unsigned FLAG_C    = 0;
   localparam int unsigned FLAG_V    = 1;
   localparam int unsigned FLAG_Z    = 2;
   localparam int unsigned FLAG_N    = 3;
   localparam int unsigned NUM_FLAGS = 4;

`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   function automatic logic is_shift(input logic [3:0] op);
      return (op >= OP_SHL) && (op <= OP_ROL);
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return (op > OP_MUL) || ((op == OP_MUL) && !MUL_EN);
   endfunction

endpackage

// File: rtl/alu_seq_step.sv
// Combinational single-step unit: arithmetic/logic ops 0-7 and one-bit
// shift/rotate steps, returning result, carry-out and signed overflow.
module alu_seq_step
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8
)(
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   sum;

   // effective second operand of the adder
   always_comb begin
      opnd = b;
      case (op)
         OP_SUB:  opnd = ~b;
         OP_INC:  opnd = '0;
         OP_DEC:  opnd = '1;
         default: opnd = b;
      endcase
   end

   assign sum = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      result = '0;
      cout   = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            result = sum[WIDTH-1:0];
            cout   = sum[WIDTH];
            ovf    = (a[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOT: result = ~a;
         OP_SHL: begin
            result = {a[WIDTH-2:0], 1'b0};
            cout   = a[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, a[WIDTH-1:1]};
            cout   = a[0];
         end
         OP_SAR: begin
            result = {a[WIDTH-1], a[WIDTH-1:1]};
            cout   = a[0];
         end
         OP_ROL: begin
            result = {a[WIDTH-2:0], a[WIDTH-1]};
            cout   = a[WIDTH-1];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes, bit-serial shifts and registered flags.
// ALU_SEQ_MUL_EN adds a shift-add multiply on op 12; without it op 12 reports err.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SHW   = $clog2(WIDTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic             err
);

   localparam int unsigned CW = SHW + 1;

   state_t               state_q, state_d;
   logic [3:0]           op_q;
   logic [WIDTH-1:0]     work_q, work_d;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     result_q;
   logic [NUM_FLAGS-1:0] flags_q;
   logic                 err_q;

   logic [3:0]           step_op;
   logic [WIDTH-1:0]     step_a, step_res;
   logic                 step_c, step_v;
   logic [SHW-1:0]       shamt;
   logic                 in_shift, in_mul, in_multi, accept, last_step, load_out;
   logic [WIDTH-1:0]     fin_res;
   logic                 fin_c, fin_v, fin_err;

   assign shamt    = b[SHW-1:0];
   assign in_shift = is_shift(op);
`ifdef ALU_SEQ_MUL_EN
   assign in_mul   = (op == OP_MUL);
`else
   assign in_mul   = 1'b0;
`endif
   assign in_multi  = (in_shift && (shamt != '0)) || in_mul;
   assign accept    = (state_q == S_IDLE) && in_valid;
   assign last_step = (state_q == S_EXEC) && (cnt_q == CW'(1));
   assign load_out  = (accept && !in_multi) || last_step;

   // one step unit serves both the accept cycle and every EXEC iteration
   assign step_op = (state_q == S_EXEC) ? op_q : op;
   assign step_a  = (state_q == S_EXEC) ? work_q : a;

   alu_seq_step #(.WIDTH(WIDTH)) u_step (
      .op     (step_op),
      .a      (step_a),
      .b      (b),
      .cin    (cin),
      .result (step_res),
      .cout   (step_c),
      .ovf    (step_v)
   );

`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] mcand_q, hi_q, hi_d;
   logic [WIDTH:0]   mul_sum;
   logic             mul_act;

   // product lives in {hi_q, work_q}; multiplier bits drain out of work_q
   assign mul_act = (op_q == OP_MUL);
   assign mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
   assign hi_d    = mul_sum[WIDTH:1];
`endif

   always_comb begin
      work_d  = step_res;
      fin_res = '0;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      fin_err = 1'b0;
      if (state_q == S_EXEC) begin
`ifdef ALU_SEQ_MUL_EN
         if (mul_act) work_d = {mul_sum[0], work_q[WIDTH-1:1]};
`endif
         fin_res = work_d;
         fin_c   = step_c;
`ifdef ALU_SEQ_MUL_EN
         if (mul_act) fin_c = |hi_d;
`endif
      end else if (is_illegal(op)) begin
         fin_err = 1'b1;
      end else if (in_shift) begin
         fin_res = a;
      end else begin
         fin_res = step_res;
         fin_c   = step_c;
         fin_v   = step_v;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = in_multi ? S_EXEC : S_DONE;
         S_EXEC:  if (cnt_q == CW'(1)) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         mcand_q  <= '0;
         hi_q     <= '0;
`endif
      end else begin
         if (accept) begin
            op_q   <= op;
            work_q <= a;
            cnt_q  <= in_mul ? CW'(WIDTH) : CW'(shamt);
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= b;
            hi_q    <= '0;
`endif
         end else if (state_q == S_EXEC) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
            if (mul_act) hi_q <= hi_d;
`endif
         end
         if (load_out) begin
            result_q        <= fin_res;
            flags_q[FLAG_C] <= fin_c;
            flags_q[FLAG_V] <= fin_v;
            flags_q[FLAG_Z] <= (fin_res == '0);
            flags_q[FLAG_N] <= fin_res[WIDTH-1];
            err_q           <= fin_err;
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign cout      = flags_q[FLAG_C];
   assign ovf       = flags_q[FLAG_V];
   assign zero      = flags_q[FLAG_Z];
   assign neg       = flags_q[FLAG_N];
   assign err       = err_q;

endmodule
